// File: rtl/axi4_bch_sender.sv
// ---------------------------------------------------------------------------
// axi4_bch_sender
//   AXI4 write-response (B channel) sender. Merges responses forwarded from
//   the downstream port with SLVERR responses owed to writes that were
//   dropped upstream. Dropped-write IDs queue in a small FIFO. A single
//   output register drives the upstream B channel, and ties between the two
//   sources alternate.
//   DROP_FIFO_DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_bch_sender #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_USER_WIDTH = 4,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                              axi4_aclk,
  input  logic                              axi4_arstn,
  // dropped-write notification
  input  logic                              drop_push,
  input  logic [C_AXI_ID_WIDTH-1:0]         drop_id,
  output logic                              drop_full,
  output logic                              drop_overflow,
  output logic [$clog2(DROP_FIFO_DEPTH):0]  drop_count,
  // downstream B channel
  input  logic [C_AXI_ID_WIDTH-1:0]         m_axi4_bid,
  input  logic [1:0]                        m_axi4_bresp,
  input  logic [C_AXI_USER_WIDTH-1:0]       m_axi4_buser,
  input  logic                              m_axi4_bvalid,
  output logic                              m_axi4_bready,
  // upstream B channel
  output logic [C_AXI_ID_WIDTH-1:0]         s_axi4_bid,
  output logic [1:0]                        s_axi4_bresp,
  output logic [C_AXI_USER_WIDTH-1:0]       s_axi4_buser,
  output logic                              s_axi4_bvalid,
  input  logic                              s_axi4_bready
);

  localparam int PTR_W = $clog2(DROP_FIFO_DEPTH);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    SRC_FWD = 1'b0,
    SRC_ERR = 1'b1
  } src_e;

  // Output register. out_src_q only changes when a candidate is loaded, so
  // it doubles as the last-grant flag used for tie-break alternation.
  logic                        out_valid_q, out_valid_d;
  logic [C_AXI_ID_WIDTH-1:0]   out_id_q,    out_id_d;
  logic [1:0]                  out_resp_q,  out_resp_d;
  logic [C_AXI_USER_WIDTH-1:0] out_user_q,  out_user_d;
  src_e                        out_src_q,   out_src_d;

  // Dropped-ID FIFO
  logic [C_AXI_ID_WIDTH-1:0]   fifo_mem_q [DROP_FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              count_q,  count_d;
  logic                        overflow_q, overflow_d;

  logic load_en;
  logic err_cand;
  logic grant_fwd;
  logic grant_err;
  logic push_ok;

  assign load_en   = ~out_valid_q | (out_valid_q & s_axi4_bready);
  assign err_cand  = (count_q != '0);
  assign drop_full = (count_q == (PTR_W+1)'(DROP_FIFO_DEPTH));
  assign push_ok   = drop_push & ~drop_full;

  // Ready is independent of m_axi4_bvalid and forced low while in reset.
  assign m_axi4_bready = axi4_arstn & load_en & (~err_cand | (out_src_q == SRC_ERR));
  assign grant_fwd     = m_axi4_bvalid & m_axi4_bready;
  assign grant_err     = load_en & err_cand & ~grant_fwd;

  assign s_axi4_bvalid = out_valid_q;
  assign s_axi4_bid    = out_id_q;
  assign s_axi4_bresp  = out_resp_q;
  assign s_axi4_buser  = out_user_q;
  assign drop_count    = count_q;
  assign drop_overflow = overflow_q;

  // Next-state for the output register and FIFO bookkeeping.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_resp_d  = out_resp_q;
    out_user_d  = out_user_q;
    out_src_d   = out_src_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q | (drop_push & drop_full);

    if (load_en) begin
      if (grant_fwd) begin
        out_valid_d = 1'b1;
        out_id_d    = m_axi4_bid;
        out_resp_d  = m_axi4_bresp;
        out_user_d  = m_axi4_buser;
        out_src_d   = SRC_FWD;
      end else if (grant_err) begin
        out_valid_d = 1'b1;
        out_id_d    = fifo_mem_q[rd_ptr_q];
        out_resp_d  = RESP_SLVERR;
        out_user_d  = '0;
        out_src_d   = SRC_ERR;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo the depth.
    if (push_ok)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (grant_err) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(grant_err);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_resp_q  <= '0;
      out_user_q  <= '0;
      out_src_q   <= SRC_ERR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_resp_q  <= out_resp_d;
      out_user_q  <= out_user_d;
      out_src_q   <= out_src_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge axi4_aclk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= drop_id;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_bch_sender.sv
// ---------------------------------------------------------------------------
// tb_axi4_bch_sender
//   Directed scenarios plus randomized traffic, checked every cycle against
//   a queue-based behavioural model of the response sender.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi4_bch_sender;

  localparam int IDW   = 4;
  localparam int UW    = 4;
  localparam int DEPTH = 4;

  logic           axi4_aclk = 1'b0;
  logic           axi4_arstn = 1'b0;
  logic           drop_push;
  logic [IDW-1:0] drop_id;
  logic           drop_full;
  logic           drop_overflow;
  logic [2:0]     drop_count;
  logic [IDW-1:0] m_axi4_bid;
  logic [1:0]     m_axi4_bresp;
  logic [UW-1:0]  m_axi4_buser;
  logic           m_axi4_bvalid;
  logic           m_axi4_bready;
  logic [IDW-1:0] s_axi4_bid;
  logic [1:0]     s_axi4_bresp;
  logic [UW-1:0]  s_axi4_buser;
  logic           s_axi4_bvalid;
  logic           s_axi4_bready;

  axi4_bch_sender #(
    .C_AXI_ID_WIDTH  (IDW),
    .C_AXI_USER_WIDTH(UW),
    .DROP_FIFO_DEPTH (DEPTH)
  ) dut (
    .axi4_aclk    (axi4_aclk),
    .axi4_arstn   (axi4_arstn),
    .drop_push    (drop_push),
    .drop_id      (drop_id),
    .drop_full    (drop_full),
    .drop_overflow(drop_overflow),
    .drop_count   (drop_count),
    .m_axi4_bid   (m_axi4_bid),
    .m_axi4_bresp (m_axi4_bresp),
    .m_axi4_buser (m_axi4_buser),
    .m_axi4_bvalid(m_axi4_bvalid),
    .m_axi4_bready(m_axi4_bready),
    .s_axi4_bid   (s_axi4_bid),
    .s_axi4_bresp (s_axi4_bresp),
    .s_axi4_buser (s_axi4_buser),
    .s_axi4_bvalid(s_axi4_bvalid),
    .s_axi4_bready(s_axi4_bready)
  );

  always #5 axi4_aclk = ~axi4_aclk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: output slot, last granted source, queue of owed IDs
  bit             mdl_valid;
  logic [IDW-1:0] mdl_id;
  logic [1:0]     mdl_resp;
  logic [UW-1:0]  mdl_user;
  bit             mdl_last_err;
  bit             mdl_ovf;
  logic [IDW-1:0] mdl_q[$];
  logic [IDW-1:0] emitted[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mdl_valid    = 1'b0;
    mdl_last_err = 1'b1;
    mdl_ovf      = 1'b0;
    mdl_q.delete();
  endtask

  task automatic set_in(input bit mv, input int mid, input int mresp, input int muser,
                        input bit push, input int pid, input bit sready);
    m_axi4_bvalid = mv;
    m_axi4_bid    = IDW'(mid);
    m_axi4_bresp  = 2'(mresp);
    m_axi4_buser  = UW'(muser);
    drop_push     = push;
    drop_id       = IDW'(pid);
    s_axi4_bready = sready;
  endtask

  // Called at a negedge with inputs applied: checks the DUT against the
  // model, then advances the model across the next rising edge.
  task automatic tick();
    bit slot_free, owed, fwd_wins, was_full;
    #1;
    owed      = (mdl_q.size() != 0);
    slot_free = !mdl_valid || s_axi4_bready;
    fwd_wins  = !owed || mdl_last_err;
    chk("m_bready", m_axi4_bready, slot_free && fwd_wins);
    chk("s_bvalid", s_axi4_bvalid, mdl_valid);
    if (mdl_valid) begin
      chk("s_bid",   s_axi4_bid,   mdl_id);
      chk("s_bresp", s_axi4_bresp, mdl_resp);
      chk("s_buser", s_axi4_buser, mdl_user);
    end
    chk("drop_count", drop_count, mdl_q.size());
    chk("drop_full",  drop_full,  mdl_q.size() == DEPTH);
    chk("drop_ovf",   drop_overflow, mdl_ovf);
    if (s_axi4_bvalid && s_axi4_bready) emitted.push_back(s_axi4_bid);
    @(posedge axi4_aclk);
    was_full = (mdl_q.size() == DEPTH);
    if (slot_free) begin
      if (m_axi4_bvalid && fwd_wins) begin
        mdl_valid = 1'b1; mdl_id = m_axi4_bid; mdl_resp = m_axi4_bresp;
        mdl_user = m_axi4_buser; mdl_last_err = 1'b0;
      end else if (owed) begin
        mdl_valid = 1'b1; mdl_id = mdl_q.pop_front(); mdl_resp = 2'b10;
        mdl_user = '0; mdl_last_err = 1'b1;
      end else begin
        mdl_valid = 1'b0;
      end
    end
    if (drop_push) begin
      if (was_full) mdl_ovf = 1'b1;
      else mdl_q.push_back(drop_id);
    end
    @(negedge axi4_aclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bvalid"}, s_axi4_bvalid, 0);
    chk({tag, "_bid"},    s_axi4_bid,    0);
    chk({tag, "_bresp"},  s_axi4_bresp,  0);
    chk({tag, "_buser"},  s_axi4_buser,  0);
    chk({tag, "_full"},   drop_full,     0);
    chk({tag, "_ovf"},    drop_overflow, 0);
    chk({tag, "_count"},  drop_count,    0);
    chk({tag, "_mready"}, m_axi4_bready, 0);
  endtask

  logic [IDW-1:0] exp_tie [5] = '{4'd5, 4'd7, 4'd1, 4'd8, 4'd2};
  logic [IDW-1:0] exp_ovf [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

  initial begin
    set_in(1, 0, 0, 0, 1, 4, 1);   // active inputs while in reset
    mdl_reset();
    #2;
    chk_reset_outputs("rst0");
    repeat (2) @(negedge axi4_aclk);
    chk_reset_outputs("rst1");
    axi4_arstn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();

    // forward pass-through, back-to-back
    set_in(1, 3, 0, 5, 0, 0, 1);
    tick();
    chk("fwd_bid", s_axi4_bid, 3);
    chk("fwd_bresp", s_axi4_bresp, 0);
    chk("fwd_buser", s_axi4_buser, 5);
    set_in(1, 4, 1, 6, 0, 0, 1);
    tick();
    chk("b2b_bvalid", s_axi4_bvalid, 1);
    chk("b2b_bid", s_axi4_bid, 4);
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();

    // error injection, +2 cycle latency
    set_in(0, 0, 0, 0, 1, 9, 1);
    tick();
    chk("err_count1", drop_count, 1);
    chk("err_not_yet", s_axi4_bvalid, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("err_bvalid", s_axi4_bvalid, 1);
    chk("err_bid", s_axi4_bid, 9);
    chk("err_bresp", s_axi4_bresp, 2);
    chk("err_buser", s_axi4_buser, 0);
    chk("err_count0", drop_count, 0);
    tick();

    // tie alternation: park ERR 5 in the slot, queue {1,2}, then contend
    set_in(0, 0, 0, 0, 1, 5, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 0, 1, 2, 0); tick();
    emitted.delete();
    set_in(1, 7, 0, 0, 0, 0, 1); tick();
    set_in(1, 8, 0, 0, 0, 0, 1); tick();
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick();
    tick();
    chk("tie_n", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++) chk("tie_order", emitted[i], exp_tie[i]);

    // backpressure
    set_in(1, 4, 0, 1, 0, 0, 0); tick();
    set_in(1, 6, 0, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_bid", s_axi4_bid, 4);
      chk("bp_mready", m_axi4_bready, 0);
    end
    s_axi4_bready = 1'b1;
    tick();
    chk("bp_next_bid", s_axi4_bid, 6);
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();

    // overflow: slot occupied, five pushes into a depth-4 FIFO
    set_in(1, 'hA, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 1, 'hB + i, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ovf_full", drop_full, 1);
    chk("ovf_sticky", drop_overflow, 1);
    chk("ovf_count", drop_count, 4);
    emitted.delete();
    s_axi4_bready = 1'b1;
    repeat (7) tick();
    chk("ovf_n", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++) chk("ovf_order", emitted[i], exp_ovf[i]);

    // reset mid-operation with s_bvalid=1 and three queued errors
    set_in(1, 3, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 1, i + 1, 0);
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_bvalid", s_axi4_bvalid, 1);
    chk("pre_rst_count", drop_count, 3);
    #1 axi4_arstn = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    mdl_reset();
    @(negedge axi4_aclk);
    @(negedge axi4_aclk);
    axi4_arstn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    emitted.delete();
    repeat (4) tick();
    chk("no_stale", emitted.size(), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 15), ($urandom_range(0, 2) == 0), $urandom_range(0, 15),
             ($urandom_range(0, 3) != 0));
      if (i >= 700 && i < 800) s_axi4_bready = 1'b0;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
